// File: rtl/pmod_da2_pkg.sv
// rtl/pmod_da2_pkg.sv - shared types and constants for the PmodDA2 serializer
package pmod_da2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int          FRAME_BITS       = 16;
    localparam logic [1:0]  PD_NORMAL        = 2'b00;
    localparam int          GAP_HALF_PERIODS = 2;

    // DAC121S101 word: two don't-care bits, power-down mode, then the 12-bit code
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [11:0] sample);
        return {2'b00, PD_NORMAL, sample};
    endfunction

endpackage

// File: rtl/pmod_da2_sclk_gen.sv
// rtl/pmod_da2_sclk_gen.sv - SCLK generator with half-period counter and edge strobes
module pmod_da2_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          sclk_r;
    logic          last;

    assign last = (cnt == CW'(CLK_DIV - 1));

    // Disabled means parked high with the counter cleared, so every frame starts with a full high half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sclk_r <= 1'b1;
        end else if (!en) begin
            cnt    <= '0;
            sclk_r <= 1'b1;
        end else if (last) begin
            cnt    <= '0;
            sclk_r <= ~sclk_r;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign sclk      = sclk_r;
    assign fall_tick = en && last && sclk_r;
    assign rise_tick = en && last && !sclk_r;

endmodule

// File: rtl/pmod_da2_tx.sv
// rtl/pmod_da2_tx.sv - dual-channel PmodDA2 serializer; PMOD_DA2_OFFSET_BINARY_EN selects two's-complement input
module pmod_da2_tx
    import pmod_da2_pkg::*;
#(
    parameter int DW      = 12,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          sclk,
    output logic          sync_n,
    output logic          d1,
    output logic          d2,
    output logic          busy,
    output logic          done
);

    localparam int GAP_CYCLES = GAP_HALF_PERIODS * CLK_DIV;
    localparam int GW         = $clog2(GAP_CYCLES) + 1;

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_BITS-1:0]   sh1;
    logic [FRAME_BITS-1:0]   sh2;
    logic [4:0]              fall_cnt;
    logic [GW-1:0]           gap_cnt;
    logic                    done_r;
    logic                    rise_tick;
    logic                    fall_tick;
    logic                    accept;
    logic                    shift_last;
    logic                    gap_last;
    logic [11:0]             s1;
    logic [11:0]             s2;

`ifdef PMOD_DA2_OFFSET_BINARY_EN
    assign s1 = {~data1[11], data1[10:0]};
    assign s2 = {~data2[11], data2[10:0]};
`else
    assign s1 = data1;
    assign s2 = data2;
`endif

    assign accept     = (state == IDLE) && in_valid;
    assign shift_last = rise_tick && (fall_cnt == 5'(FRAME_BITS));
    assign gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));

    pmod_da2_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk       (clk),
        .rst_n     (rst),
        .en        (state == SHIFT),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (shift_last) state_next = GAP;
            GAP:     if (gap_last)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Data only advances on SCLK rising strobes, so it is stable across every falling edge the DAC samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh1      <= '0;
            sh2      <= '0;
            fall_cnt <= '0;
            gap_cnt  <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state == GAP) && gap_last;
            if (accept) begin
                sh1      <= frame_word(s1);
                sh2      <= frame_word(s2);
                fall_cnt <= '0;
                gap_cnt  <= '0;
            end else if (state == SHIFT) begin
                if (fall_tick) begin
                    fall_cnt <= fall_cnt + 1'b1;
                end
                if (rise_tick) begin
                    sh1 <= {sh1[FRAME_BITS-2:0], 1'b0};
                    sh2 <= {sh2[FRAME_BITS-2:0], 1'b0};
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        sync_n   = (state != SHIFT);
        d1       = (state == SHIFT) && sh1[FRAME_BITS-1];
        d2       = (state == SHIFT) && sh2[FRAME_BITS-1];
        done     = done_r;
    end

endmodule
